// File: rtl/puf_challenge_sequencer_if.sv
// Host/array-side bundle for the RO PUF challenge sequencer.
// master drives start/abort/offset and the counter values; slave is the sequencer.
interface puf_challenge_sequencer_if #(
  parameter int NBITS = 16,
  parameter int CW    = 12
);
  logic             start;
  logic             abort;
  logic [3:0]       offset;
  logic [CW-1:0]    counter1_out;
  logic [CW-1:0]    counter2_out;
  logic [3:0]       select1;
  logic [3:0]       select2;
  logic             ro_enable;
  logic             ro_reset;
  logic [CW-1:0]    clockcounter_out;
  logic             busy;
  logic             done;
  logic             err;
  logic             sat;
  logic [NBITS-1:0] response;
  logic [NBITS-1:0] tie_mask;

  modport master (
    output start, abort, offset,
    output counter1_out, counter2_out,
    input  select1, select2,
    input  ro_enable, ro_reset,
    input  clockcounter_out,
    input  busy, done, err, sat,
    input  response, tie_mask
  );

  modport slave (
    input  start, abort, offset,
    input  counter1_out, counter2_out,
    output select1, select2,
    output ro_enable, ro_reset,
    output clockcounter_out,
    output busy, done, err, sat,
    output response, tie_mask
  );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// Steps the RO PUF through clear/run/settle/compare per response bit,
// building the response, tie mask and saturation flag.
module puf_challenge_sequencer #(
  parameter int NBITS      = 16,
  parameter int WINDOW     = 2048,
  parameter int CLR_CYCLES = 4,
  parameter int SETTLE     = 8,
  parameter int CW         = 12
) (
  input logic clock,
  input logic reset,
  puf_challenge_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_COMPARE
  } state_t;

  localparam logic [15:0]   CLR_LAST = 16'(CLR_CYCLES - 1);
  localparam logic [15:0]   SET_LAST = 16'(SETTLE - 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);
  localparam logic [3:0]    K_LAST   = 4'(NBITS - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [15:0]      ph_q, ph_d;
  logic [CW-1:0]    cc_q, cc_d;
  logic [3:0]       k_q, k_d;
  logic [3:0]       off_q, off_d;
  logic [3:0]       sel1_q, sel1_d;
  logic [3:0]       sel2_q, sel2_d;
  logic             ren_q, ren_d;
  logic             rrst_q, rrst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             sat_q, sat_d;
  logic [NBITS-1:0] resp_q, resp_d;
  logic [NBITS-1:0] tie_q, tie_d;
  logic [3:0]       k_nx;

  assign k_nx = k_q + 4'd1;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cc_d    = cc_q;
    k_d     = k_q;
    off_d   = off_q;
    sel1_d  = sel1_q;
    sel2_d  = sel2_q;
    done_d  = 1'b0;
    err_d   = err_q;
    sat_d   = sat_q;
    resp_d  = resp_q;
    tie_d   = tie_q;
    // abort wins over every transition, including a COMPARE write
    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.offset != 4'd0) begin
              err_d   = 1'b0;
              sat_d   = 1'b0;
              resp_d  = '0;
              tie_d   = '0;
              k_d     = 4'd0;
              off_d   = bus.offset;
              sel1_d  = 4'd0;
              sel2_d  = bus.offset;
              ph_d    = '0;
              cc_d    = '0;
              state_d = S_CLEAR;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_CLEAR: begin
          cc_d = '0;
          if (ph_q == CLR_LAST) begin
            ph_d    = '0;
            state_d = S_RUN;
          end else begin
            ph_d = ph_q + 16'd1;
          end
        end
        S_RUN: begin
          if (cc_q == WIN_LAST) begin
            ph_d    = '0;
            state_d = S_SETTLE;
          end else begin
            cc_d = cc_q + CW'(1);
          end
        end
        S_SETTLE: begin
          if (ph_q == SET_LAST) begin
            ph_d    = '0;
            state_d = S_COMPARE;
          end else begin
            ph_d = ph_q + 16'd1;
          end
        end
        S_COMPARE: begin
          for (int i = 0; i < NBITS; i++) begin
            if (k_q == 4'(i)) begin
              resp_d[i] = bus.counter1_out > bus.counter2_out;
              tie_d[i]  = bus.counter1_out == bus.counter2_out;
            end
          end
          if (bus.counter1_out == CNT_MAX || bus.counter2_out == CNT_MAX)
            sat_d = 1'b1;
          if (k_q == K_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            k_d     = k_nx;
            sel1_d  = k_nx;
            sel2_d  = k_nx + off_q;
            cc_d    = '0;
            state_d = S_CLEAR;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    rrst_d = (state_d == S_CLEAR);
    ren_d  = (state_d == S_RUN);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      cc_q    <= '0;
      k_q     <= '0;
      off_q   <= '0;
      sel1_q  <= '0;
      sel2_q  <= '0;
      ren_q   <= 1'b0;
      rrst_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sat_q   <= 1'b0;
      resp_q  <= '0;
      tie_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cc_q    <= cc_d;
      k_q     <= k_d;
      off_q   <= off_d;
      sel1_q  <= sel1_d;
      sel2_q  <= sel2_d;
      ren_q   <= ren_d;
      rrst_q  <= rrst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
    end
  end

  assign bus.select1          = sel1_q;
  assign bus.select2          = sel2_q;
  assign bus.ro_enable        = ren_q;
  assign bus.ro_reset         = rrst_q;
  assign bus.clockcounter_out = cc_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.err              = err_q;
  assign bus.sat              = sat_q;
  assign bus.response         = resp_q;
  assign bus.tie_mask         = tie_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Randomised bench for puf_challenge_sequencer against a timing-formula model,
// plus directed scenarios with literal expectations.
module tb_puf_challenge_sequencer;

  localparam int NB  = 4;
  localparam int W   = 16;
  localparam int CL  = 2;
  localparam int ST  = 2;
  localparam int CW  = 12;
  localparam int P   = CL + W + ST + 1;
  localparam int LEN = NB * P;

  logic clk;
  logic rst_n;

  puf_challenge_sequencer_if #(.NBITS(NB), .CW(CW)) bus ();

  puf_challenge_sequencer #(
    .NBITS(NB), .WINDOW(W), .CLR_CYCLES(CL), .SETTLE(ST), .CW(CW)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nasserts = 0;
  int nfail    = 0;
  bit chk_en   = 0;

  logic [CW-1:0] c1a [NB];
  logic [CW-1:0] c2a [NB];

  // model state
  bit            m_run;
  int            m_n;
  logic [3:0]    m_off;
  logic [3:0]    m_sel1, m_sel2;
  logic [CW-1:0] m_cc;
  bit            m_ren, m_rrst, m_busy, m_done, m_err, m_sat;
  logic [NB-1:0] m_resp, m_tie;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nasserts++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_n = 0; m_off = 0; m_sel1 = 0; m_sel2 = 0; m_cc = 0;
    m_ren = 0; m_rrst = 0; m_busy = 0; m_done = 0; m_err = 0; m_sat = 0;
    m_resp = 0; m_tie = 0;
  endtask

  // Advance the model by one clock edge from the inputs presented before it.
  task automatic model_edge();
    int b, j;
    m_done = 0;
    if (!m_run) begin
      if (bus.start) begin
        if (bus.offset != 0) begin
          m_run = 1; m_n = 0; m_off = bus.offset; m_err = 0;
          m_resp = 0; m_tie = 0; m_sat = 0;
        end else m_err = 1;
      end
    end else if (bus.abort) begin
      m_run = 0;
    end else begin
      b = m_n / P;
      m_n++;
      if (m_n % P == 0) begin
        m_resp[b] = bus.counter1_out > bus.counter2_out;
        m_tie[b]  = bus.counter1_out == bus.counter2_out;
        if (bus.counter1_out == 12'hFFF || bus.counter2_out == 12'hFFF)
          m_sat = 1;
        if (b == NB - 1) begin
          m_run = 0; m_done = 1;
        end
      end
    end
    if (m_run) begin
      b = m_n / P; j = m_n % P;
      m_sel1 = 4'(b);
      m_sel2 = 4'((b + int'(m_off)) % 16);
      m_rrst = j < CL;
      m_ren  = (j >= CL) && (j < CL + W);
      m_cc   = (j < CL) ? 0 : (j < CL + W) ? CW'(j - CL) : CW'(W - 1);
      m_busy = 1;
    end else begin
      m_busy = 0; m_ren = 0; m_rrst = 0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("select1", 32'(bus.select1), 32'(m_sel1));
      chk("select2", 32'(bus.select2), 32'(m_sel2));
      chk("ro_enable", 32'(bus.ro_enable), 32'(m_ren));
      chk("ro_reset", 32'(bus.ro_reset), 32'(m_rrst));
      chk("clockcounter", 32'(bus.clockcounter_out), 32'(m_cc));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("err", 32'(bus.err), 32'(m_err));
      chk("sat", 32'(bus.sat), 32'(m_sat));
      chk("response", 32'(bus.response), 32'(m_resp));
      chk("tie_mask", 32'(bus.tie_mask), 32'(m_tie));
    end
  end

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sel1"}, 32'(bus.select1), 0);
    chk({tag, "_sel2"}, 32'(bus.select2), 0);
    chk({tag, "_ren"}, 32'(bus.ro_enable), 0);
    chk({tag, "_rrst"}, 32'(bus.ro_reset), 0);
    chk({tag, "_cc"}, 32'(bus.clockcounter_out), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
    chk({tag, "_sat"}, 32'(bus.sat), 0);
    chk({tag, "_resp"}, 32'(bus.response), 0);
    chk({tag, "_tie"}, 32'(bus.tie_mask), 0);
  endtask

  int            done_edge;
  logic [3:0]    fp1, fp2;
  logic          fe, fs;

  // One start followed by a bounded window of cycles.
  task automatic run(input logic [3:0] off, input int abort_at,
                     input int rst_at, input bit rnd_start);
    int b;
    done_edge = -1;
    bus.offset = off;
    bus.start  = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int n = 0; n < LEN + 3; n++) begin
      if (n == 0) begin
        fp1 = bus.select1; fp2 = bus.select2; fe = bus.err; fs = bus.sat;
      end
      if (bus.done && done_edge < 0) done_edge = n;
      b = m_n / P;
      if (m_run && b < NB) begin
        bus.counter1_out = c1a[b];
        bus.counter2_out = c2a[b];
      end else begin
        bus.counter1_out = '0;
        bus.counter2_out = '0;
      end
      bus.abort = (n == abort_at);
      bus.start = rnd_start && m_run && ($urandom_range(0, 7) == 0);
      if (n == rst_at) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
      end
      cyc();
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic set_all(input int v1, input int v2);
    for (int i = 0; i < NB; i++) begin
      c1a[i] = CW'(v1);
      c2a[i] = CW'(v2);
    end
  endtask

  initial begin
    bus.start = 0; bus.abort = 0; bus.offset = 0;
    bus.counter1_out = 0; bus.counter2_out = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    chk_en = 1;
    cyc();

    // all bits c1 > c2
    set_all(100, 90);
    run(4'd1, -1, -1, 0);
    chk("A_done_edge", 32'(done_edge), 84);
    chk("A_resp", 32'(bus.response), 32'b1111);
    chk("A_tie", 32'(bus.tie_mask), 0);
    chk("A_sel", {bus.select1, bus.select2}, 8'h34);

    // tie on bit 2, c1 < c2 elsewhere
    set_all(10, 20);
    c1a[2] = 50; c2a[2] = 50;
    run(4'd1, -1, -1, 0);
    chk("B_resp", 32'(bus.response), 0);
    chk("B_tie", 32'(bus.tie_mask), 32'b0100);

    // illegal offset, then a legal start clears err
    run(4'd0, -1, -1, 0);
    chk("C_err", 32'(bus.err), 1);
    chk("C_busy", 32'(bus.busy), 0);
    chk("C_no_done", 32'(done_edge), 32'(-1));
    set_all(7, 3);
    run(4'd5, -1, -1, 0);
    chk("C_first_pair", {fp1, fp2}, 8'h05);
    chk("C_err_clr", 32'(fe), 0);

    // abort in RUN of bit 1
    set_all(200, 100);
    run(4'd1, P + CL + 5, -1, 0);
    chk("D_no_done", 32'(done_edge), 32'(-1));
    chk("D_resp", 32'(bus.response), 32'b0001);
    chk("D_ren", 32'(bus.ro_enable), 0);
    chk("D_busy", 32'(bus.busy), 0);

    // saturation on bit 0, then cleared by next start
    set_all(5, 6);
    c1a[0] = 12'hFFF;
    run(4'd3, -1, -1, 0);
    chk("E_sat", 32'(bus.sat), 1);
    set_all(5, 6);
    run(4'd3, -1, -1, 0);
    chk("E_sat_clr", 32'(fs), 0);

    // reset in SETTLE of bit 2, then a clean full run
    set_all(100, 90);
    run(4'd2, -1, 2 * P + CL + W, 0);
    run(4'd2, -1, -1, 0);
    chk("F_done_edge", 32'(done_edge), 84);
    chk("F_resp", 32'(bus.response), 32'b1111);

    // randomised runs
    for (int r = 0; r < 24; r++) begin
      logic [3:0] off;
      int ab;
      for (int i = 0; i < NB; i++) begin
        c1a[i] = CW'($urandom_range(0, 4095));
        c2a[i] = ($urandom_range(0, 3) == 0) ? c1a[i]
                                             : CW'($urandom_range(0, 4095));
        if ($urandom_range(0, 7) == 0) c1a[i] = 12'hFFF;
      end
      off = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LEN - 1)) : -1;
      run(off, ab, -1, 1);
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             nasserts, nfail);
    $finish;
  end

endmodule
